xilinx_rst_conditioner: RTL and testbench



---
 rtl/xilinx_rst_conditioner.sv | 175 +++++++++++++++++
 tb/tb_xilinx_rst_conditioner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_rst_conditioner.sv
// -----------------------------------------------------------------------------
// xilinx_rst_conditioner
//
// Board-level reset conditioner for the FPGA top-level wrapper. Combines the
// raw reset button and the clock wizard's locked flag into one registered,
// active-low reset for the SoC and the reset LED. Reset is released only once
// the clock is locked, the button is released, and a stretch interval has
// elapsed.
//
// Ports:
//   clk_i          in   generated system clock
//   rst_ni         in   global async reset, active-low
//   btn_i          in   raw board reset button (async, polarity by parameter)
//   clk_locked_i   in   clock wizard locked flag (async)
//   rst_no         out  conditioned SoC reset, active-low, registered
//   rst_led_o      out  copy of rst_no for the reset LED
//   lock_lost_o    out  sticky: lock was lost while in RUN
//   reset_count_o  out  saturating count of RUN->HOLD transitions
//
// state    | meaning
// ---------+-------------------------------------------------------------
// HOLD     | reset asserted, waiting for lock and button released
// STRETCH  | lock stable and button released, counting stretch interval
// RUN      | reset released
// -----------------------------------------------------------------------------
module xilinx_rst_conditioner #(
    parameter int BTN_ACTIVE_HIGH = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int STRETCH_CYCLES  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_i,
    input  logic       clk_locked_i,
    output logic       rst_no,
    output logic       rst_led_o,
    output logic       lock_lost_o,
    output logic [7:0] reset_count_o
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(STRETCH_CYCLES) + 1;

    // Raw button level that means "not pressed"; also the synchronizer reset value.
    localparam logic BTN_IDLE = (BTN_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_MAX = SW'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   btn_s;
    logic                   lock_s;

    logic                   btn_db;
    logic [DW-1:0]          dcnt;

    state_t                 state_q;
    state_t                 state_d;
    logic [SW-1:0]          scnt_q;
    logic [SW-1:0]          scnt_d;
    logic                   run_exit;

    // -------------------------------------------------------------------------
    // Synchronizers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync  <= {SYNC_STAGES{BTN_IDLE}};
            lock_sync <= '0;
        end else begin
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_i};
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], clk_locked_i};
        end
    end

    // XOR with the idle level normalizes the button so pressed = 1.
    assign btn_s  = btn_sync[SYNC_STAGES-1] ^ BTN_IDLE;
    assign lock_s = lock_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debouncer: btn_db follows btn_s only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_db <= 1'b0;
            dcnt   <= '0;
        end else if (btn_s == btn_db) begin
            dcnt   <= '0;
        end else if (dcnt == DCNT_MAX) begin
            btn_db <= ~btn_db;
            dcnt   <= '0;
        end else begin
            dcnt   <= dcnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencing FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_HOLD;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            ST_HOLD: begin
                if (lock_s && !btn_db) begin
                    state_d = ST_STRETCH;
                    scnt_d  = '0;
                end
            end
            ST_STRETCH: begin
                if (!lock_s || btn_db) begin
                    state_d = ST_HOLD;
                end else if (scnt_q == SCNT_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    scnt_d  = scnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s || btn_db) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign run_exit = (state_q == ST_RUN) && (state_d == ST_HOLD);

    // -------------------------------------------------------------------------
    // Outputs and status. rst_no is loaded from next_state so it moves on the
    // same edge as the state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_no        <= 1'b0;
            lock_lost_o   <= 1'b0;
            reset_count_o <= 8'd0;
        end else begin
            rst_no <= (state_d == ST_RUN);
            if (run_exit) begin
                if (reset_count_o != 8'hFF) begin
                    reset_count_o <= reset_count_o + 8'd1;
                end
                if (!lock_s) begin
                    lock_lost_o <= 1'b1;
                end
            end
        end
    end

    assign rst_led_o = rst_no;

endmodule

// File: tb/tb_xilinx_rst_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for xilinx_rst_conditioner (SYNC=2, DEBOUNCE=8, STRETCH=16,
// active-high button). A behavioural model tracks the expected outputs every
// cycle; table vectors and hand sequences check the timing corner cases
// against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_xilinx_rst_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int STR  = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       btn_i = 1'b0;
    logic       clk_locked_i = 1'b1;
    logic       rst_no;
    logic       rst_led_o;
    logic       lock_lost_o;
    logic [7:0] reset_count_o;

    int total = 0;
    int bad   = 0;

    xilinx_rst_conditioner #(
        .BTN_ACTIVE_HIGH (1),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .STRETCH_CYCLES  (STR)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .btn_i         (btn_i),
        .clk_locked_i  (clk_locked_i),
        .rst_no        (rst_no),
        .rst_led_o     (rst_led_o),
        .lock_lost_o   (lock_lost_o),
        .reset_count_o (reset_count_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural reference model ----------------
    // Inputs are seen SYNC edges late. The debounced button flips once the
    // last DEB synchronized samples all disagree with it. Reset is released
    // once "locked and not pressed" has held for STR+1 consecutive edges.
    bit lq[$];
    bit bq[$];
    bit bwin[$];
    bit m_db;
    int okrun;
    bit m_rst;
    int m_cnt;
    bit m_lost;

    task automatic model_reset();
        lq = {};
        bq = {};
        bwin = {};
        for (int i = 0; i < SYNC; i++) begin
            lq.push_back(1'b0);
            bq.push_back(1'b0);
        end
        m_db   = 1'b0;
        okrun  = 0;
        m_rst  = 1'b0;
        m_cnt  = 0;
        m_lost = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit l);
        bit lock_s;
        bit btn_s;
        bit nrst;
        bit all_diff;
        lock_s = lq[0];
        btn_s  = bq[0];
        if (lock_s && !m_db) okrun = (okrun < 100000) ? okrun + 1 : okrun;
        else okrun = 0;
        nrst = (okrun > STR);
        if (m_rst && !nrst) begin
            if (m_cnt < 255) m_cnt++;
            if (!lock_s) m_lost = 1'b1;
        end
        m_rst = nrst;
        bwin.push_back(btn_s);
        if (bwin.size() > DEB) void'(bwin.pop_front());
        if (bwin.size() == DEB) begin
            all_diff = 1'b1;
            foreach (bwin[i]) if (bwin[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = !m_db;
        end
        lq.push_back(l);
        void'(lq.pop_front());
        bq.push_back(b);
        void'(bq.pop_front());
    endtask

    task automatic model_cmp();
        total++;
        if (rst_no !== m_rst || rst_led_o !== m_rst || lock_lost_o !== m_lost ||
            reset_count_o !== 8'(m_cnt)) begin
            bad++;
            $display("FAIL model t=%0t: got rst=%0b led=%0b cnt=%0d lost=%0b, want rst=%0b cnt=%0d lost=%0b",
                     $time, rst_no, rst_led_o, reset_count_o, lock_lost_o, m_rst, m_cnt, m_lost);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, model the posedge, compare 1 ns after it.
    task automatic cyc(input bit r, input bit b, input bit l);
        @(negedge clk_i);
        rst_ni = r;
        btn_i = b;
        clk_locked_i = l;
        @(posedge clk_i);
        if (r) model_step(b, l);
        else model_reset();
        #1;
        model_cmp();
    endtask

    // Called 1 ns after a posedge: asserts rst_ni and checks before next edge.
    task automatic async_rst_check(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        chk({tag, "_rst_no"}, int'(rst_no), 0);
        chk({tag, "_led"}, int'(rst_led_o), 0);
        chk({tag, "_cnt"}, int'(reset_count_o), 0);
        chk({tag, "_lost"}, int'(lock_lost_o), 0);
        model_reset();
    endtask

    task automatic powerup_check(input string tag);
        repeat (5) cyc(0, 0, 1);
        repeat (18) cyc(1, 0, 1);
        chk({tag, "_pre_rst"}, int'(rst_no), 0);
        chk({tag, "_pre_led"}, int'(rst_led_o), 0);
        cyc(1, 0, 1);
        chk({tag, "_rel_rst"}, int'(rst_no), 1);
        chk({tag, "_rel_cnt"}, int'(reset_count_o), 0);
        chk({tag, "_rel_lost"}, int'(lock_lost_o), 0);
    endtask

    typedef struct {
        string name;
        bit    btn;
        bit    lock;
        int    n;
        bit    e_rst;
        int    e_cnt;
        bit    e_lost;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input bit b, input bit l, input int n,
                                input bit r, input int c, input bit lo);
        vec_t v;
        v.name = nm; v.btn = b; v.lock = l; v.n = n;
        v.e_rst = r; v.e_cnt = c; v.e_lost = lo;
        return v;
    endfunction

    initial begin
        model_reset();

        // Power-up, debounce, lock loss in RUN, lock drop in STRETCH.
        vecs.push_back(mk("pwr_pre",       0, 1, 18, 0, 0, 0));
        vecs.push_back(mk("pwr_rel",       0, 1,  1, 1, 0, 0));
        vecs.push_back(mk("glitch7",       1, 1,  7, 1, 0, 0));
        vecs.push_back(mk("glitch_settle", 0, 1, 10, 1, 0, 0));
        vecs.push_back(mk("press_pre",     1, 1, 10, 1, 0, 0));
        vecs.push_back(mk("press_fall",    1, 1,  1, 0, 1, 0));
        vecs.push_back(mk("press_hold",    1, 1,  9, 0, 1, 0));
        vecs.push_back(mk("release_pre",   0, 1, 26, 0, 1, 0));
        vecs.push_back(mk("release_rise",  0, 1,  1, 1, 1, 0));
        vecs.push_back(mk("lockloss_pre",  0, 0,  2, 1, 1, 0));
        vecs.push_back(mk("lockloss_fall", 0, 0,  1, 0, 2, 1));
        vecs.push_back(mk("stretch_to10",  0, 1, 13, 0, 2, 1));
        vecs.push_back(mk("stretch_drop",  0, 0,  4, 0, 2, 1));
        vecs.push_back(mk("relock_pre",    0, 1, 18, 0, 2, 1));
        vecs.push_back(mk("relock_rel",    0, 1,  1, 1, 2, 1));

        repeat (5) cyc(0, 0, 1);
        chk("reset_rst_no", int'(rst_no), 0);
        chk("reset_cnt", int'(reset_count_o), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n) cyc(1, vecs[i].btn, vecs[i].lock);
            chk({vecs[i].name, "_rst"}, int'(rst_no), int'(vecs[i].e_rst));
            chk({vecs[i].name, "_led"}, int'(rst_led_o), int'(vecs[i].e_rst));
            chk({vecs[i].name, "_cnt"}, int'(reset_count_o), vecs[i].e_cnt);
            chk({vecs[i].name, "_lost"}, int'(lock_lost_o), int'(vecs[i].e_lost));
        end

        // Async reset while in RUN with count 2, then mid-STRETCH.
        async_rst_check("arst_run");
        powerup_check("pwr2");
        repeat (5) cyc(0, 0, 1);
        repeat (10) cyc(1, 0, 1);
        async_rst_check("arst_stretch");
        powerup_check("pwr3");

        // Randomized segments against the model.
        for (int s = 0; s < 60; s++) begin
            bit b;
            bit l;
            int len;
            b   = ($urandom_range(0, 2) == 0);
            l   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 30);
            repeat (len) cyc(1, b, l);
        end

        // Saturation: settle into RUN, then 300 debounced press/release cycles.
        repeat (40) cyc(1, 0, 1);
        chk("sat_start_run", int'(rst_no), 1);
        for (int k = 0; k < 300; k++) begin
            int pl;
            int rl;
            pl = $urandom_range(11, 15);
            rl = $urandom_range(28, 34);
            repeat (pl) cyc(1, 1, 1);
            repeat (rl) cyc(1, 0, 1);
        end
        chk("sat_cnt", int'(reset_count_o), 255);
        chk("sat_run", int'(rst_no), 1);
        repeat (12) cyc(1, 1, 1);
        chk("sat_cnt_hold", int'(reset_count_o), 255);
        repeat (30) cyc(1, 0, 1);

        // Async reset in RUN with the count saturated; power-up repeats.
        async_rst_check("arst_sat");
        powerup_check("pwr4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
